m68k_irq_ctrl: RTL
==================

Name: m68k_irq_ctrl

Overview:
- Consumes the 68000-side `int_en_cs` and `vblank_cs` selects produced by the address decoder.
- Turns the video timing vblank into a level-4 autovectored interrupt for the main 68000, held until the CPU acknowledges it.
- Owns the interrupt-enable register and returns read data for the vblank status port.
- Sits between the address decoder, the video timing generator and the fx68k IPL/VPA inputs.

Parameters:
- IRQ_LEVEL, 4: interrupt priority level driven on IPL and matched during acknowledge.
- VBL_ACTIVE_HIGH, 1: polarity of the `vbl` input; 0 inverts it internally.

Ports:
- clk_sys  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cpu_as_n  in  1  68000 address strobe.
- cpu_rw  in  1  68000 read/write; 1 = read.
- cpu_lds_n  in  1  68000 lower data strobe.
- cpu_fc  in  3  68000 function code.
- cpu_a  in  3  68000 address bits A3..A1.
- cpu_dout  in  16  68000 write data.
- int_en_cs  in  1  select for the interrupt-enable register (write).
- vblank_cs  in  1  select for the vblank status port (read).
- vbl  in  1  vertical blank from video timing, synchronous to clk_sys.
- ipl_n  out  3  encoded interrupt priority to the CPU, active low.
- vpa_n  out  1  autovector request during acknowledge.
- cpu_din  out  16  read data for the vblank status port.
- int_en  out  1  interrupt-enable register, visible for debug.
- irq_pending  out  1  pending level-IRQ_LEVEL interrupt.

Behaviour:
- Reset (async, reset_n = 0) values:
  - int_en = 0, irq_pending = 0.
  - ipl_n = 3'b111, vpa_n = 1, cpu_din = 0.
  - Internal vbl_d = 0, wr_seen = 0, iack_seen = 0.
- Reset mid-bus-cycle: reset aborts any acknowledge or write in progress. After release, a write or acknowledge whose strobe is still asserted is not honoured; the next strobe assertion is.
- vblank edge:
  - `vbl_i` = `vbl` XNOR VBL_ACTIVE_HIGH. `vbl_d` is the registered `vbl_i`.
  - A rise is `vbl_i` & !`vbl_d`.
  - On a rise with int_en = 1, irq_pending is set on the next edge.
  - A rise with int_en = 0 is dropped, not remembered.
- Enable write:
  - A write cycle is int_en_cs & !cpu_as_n & !cpu_rw & !cpu_lds_n.
  - Commit happens only on the first clk_sys edge of the write cycle; `wr_seen` blocks repeats and clears when cpu_as_n = 1.
  - On commit, int_en = |cpu_dout[7:0].
  - Writing 0 also clears irq_pending on the same edge.
- Interrupt acknowledge:
  - An acknowledge cycle is !cpu_as_n & cpu_fc = 3'b111 & cpu_a = IRQ_LEVEL.
  - On the first edge of the acknowledge cycle (`iack_seen` guard), irq_pending is cleared.
  - vpa_n is registered: low from the edge after acknowledge detection until the edge after cpu_as_n goes high.
  - An acknowledge for any other level leaves vpa_n = 1 and irq_pending unchanged.
- IPL output: registered. ipl_n = ~IRQ_LEVEL[2:0] when irq_pending, else 3'b111. This gives one cycle of latency after irq_pending.
- Priority when events coincide on one edge:
  - Enable-write-0 beats everything: irq_pending = 0.
  - Otherwise a vblank rise beats acknowledge: irq_pending stays 1, so a new frame's IRQ is never lost.
- Read port: cpu_din = {15'h0, `vbl_i`} registered while vblank_cs & cpu_rw & !cpu_as_n; otherwise 16'h0000.
- Steady vbl gives no repeat IRQ; exactly one IRQ per rising edge.

Test Plan:
- Reset release, vbl toggling, no enable write: ipl_n stays 3'b111 and irq_pending stays 0 across 3 frames.
- Write 16'h0001 to int_en_cs, then raise vbl: irq_pending = 1 one edge after the rise; ipl_n = 3'b011 one edge later.
- With the IRQ pending, run an acknowledge with fc = 7, A3..A1 = 4 for 4 clocks: irq_pending clears on the first edge, vpa_n is low from the second edge, vpa_n returns to 1 the edge after cpu_as_n rises, ipl_n = 3'b111.
- Acknowledge with A3..A1 = 2 while pending: vpa_n stays 1 and irq_pending stays 1.
- Vblank rise on the same edge as the first acknowledge edge: irq_pending remains 1. Write 16'h0000 on the same edge as a vblank rise: irq_pending = 0 and int_en = 0.
- Read vblank_cs during vbl = 1, then vbl = 0: cpu_din = 16'h0001, then 16'h0000. Assert reset_n = 0 mid-acknowledge: vpa_n = 1, ipl_n = 3'b111 immediately; no acknowledge honoured until cpu_as_n cycles high.

Source files
------------

// File: rtl/m68k_irq_ctrl.sv
// Vblank interrupt controller for the main 68000: latches a level-IRQ_LEVEL
// autovectored IRQ on each vblank rise, owns the enable register and the status port.
module m68k_irq_ctrl #(
    parameter int IRQ_LEVEL       = 4,
    parameter bit VBL_ACTIVE_HIGH = 1'b1
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        cpu_as_n,
    input  logic        cpu_rw,
    input  logic        cpu_lds_n,
    input  logic [2:0]  cpu_fc,
    input  logic [2:0]  cpu_a,
    input  logic [15:0] cpu_dout,
    input  logic        int_en_cs,
    input  logic        vblank_cs,
    input  logic        vbl,
    output logic [2:0]  ipl_n,
    output logic        vpa_n,
    output logic [15:0] cpu_din,
    output logic        int_en,
    output logic        irq_pending
);

    localparam logic [2:0] LEVEL = 3'(IRQ_LEVEL);

    logic vbl_i;
    logic vbl_d;
    logic vbl_rise;
    logic wr_cycle;
    logic wr_seen;
    logic wr_commit;
    logic wr_value;
    logic iack_cycle;
    logic iack_seen;
    logic iack_first;
    logic bus_armed;
    logic pending_next;
    logic unused_hi;

    assign vbl_i    = ~(vbl ^ VBL_ACTIVE_HIGH);
    assign vbl_rise = vbl_i & ~vbl_d;

    assign wr_cycle   = int_en_cs & ~cpu_as_n & ~cpu_rw & ~cpu_lds_n;
    assign iack_cycle = ~cpu_as_n & (cpu_fc == 3'b111) & (cpu_a == LEVEL);

    // A strobe already low when reset releases belongs to an aborted cycle,
    // so nothing is honoured until the address strobe has been seen high once.
    assign wr_commit  = wr_cycle & ~wr_seen & bus_armed;
    assign iack_first = iack_cycle & ~iack_seen & bus_armed;
    assign wr_value   = |cpu_dout[7:0];
    assign unused_hi  = ^cpu_dout[15:8];

    // Disabling wins outright; a fresh vblank rise outranks the acknowledge so
    // a new frame's IRQ is never swallowed by the ack of the previous one.
    always_comb begin
        pending_next = irq_pending;
        if (wr_commit && !wr_value)
            pending_next = 1'b0;
        else if (vbl_rise && int_en)
            pending_next = 1'b1;
        else if (iack_first)
            pending_next = 1'b0;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            bus_armed <= 1'b0;
            wr_seen   <= 1'b0;
            iack_seen <= 1'b0;
        end else begin
            if (cpu_as_n) begin
                bus_armed <= 1'b1;
                wr_seen   <= 1'b0;
                iack_seen <= 1'b0;
            end else begin
                if (wr_commit)
                    wr_seen <= 1'b1;
                if (iack_first)
                    iack_seen <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            vbl_d       <= 1'b0;
            int_en      <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            vbl_d       <= vbl_i;
            irq_pending <= pending_next;
            if (wr_commit)
                int_en <= wr_value;
        end
    end

    // vpa_n drops the edge after the ack is detected and rises on the first
    // edge that sees the address strobe released.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ipl_n   <= 3'b111;
            vpa_n   <= 1'b1;
            cpu_din <= 16'h0000;
        end else begin
            ipl_n   <= irq_pending ? ~LEVEL : 3'b111;
            vpa_n   <= ~(iack_seen & iack_cycle);
            cpu_din <= (vblank_cs && cpu_rw && !cpu_as_n) ? {15'h0000, vbl_i} : 16'h0000;
        end
    end

endmodule
